vfpu_tile_sequencer: RTL

- Sequential successor to the combinational register-to-streamer control mapping of the VFPU HWPE.
- Runs a programmed number of tiles back-to-back. Per tile: start all NB_OPERANDS source streams and the result sink with per-tile base addresses, wait for every stream's done, then advance.
- Adds a per-tile watchdog and an error flag.
- Sits between the hwpe_ctrl slave (start, config) and the streamer ctrl/flags.

---
 rtl/vfpu_tile_sequencer_pkg.sv | 23 ++
 rtl/vfpu_tile_sequencer_if.sv | 26 ++
 rtl/vfpu_stream_done_tracker.sv | 29 ++
 rtl/vfpu_tile_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vfpu_tile_sequencer_pkg.sv
// Shared types and register map additions for the VFPU tile sequencer.
package vfpu_tile_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        NEXT,
        DONE
    } seq_state_e;

    // Register-file indices for the tiling configuration fields.
    localparam int unsigned REG_N_TILES         = 8;
    localparam int unsigned REG_TIMEOUT         = 9;
    localparam int unsigned REG_SINK_STRIDE     = 10;
    localparam int unsigned REG_SRC_STRIDE_BASE = 11;

    // Register index of the per-tile stride for source operand op.
    function automatic int unsigned reg_src_stride(input int unsigned op);
        return REG_SRC_STRIDE_BASE + op;
    endfunction

endpackage

// File: rtl/vfpu_tile_sequencer_if.sv
// Streamer control/flag bundle between the tile sequencer and the streamers.
interface vfpu_tile_sequencer_if #(
    parameter int unsigned NB_OPERANDS = 2,
    parameter int unsigned ADDR_WIDTH  = 32
);

    logic [NB_OPERANDS-1:0]                 src_req_start;
    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_base_addr;
    logic [NB_OPERANDS-1:0]                 src_done;
    logic                                   sink_req_start;
    logic [ADDR_WIDTH-1:0]                  sink_base_addr;
    logic                                   sink_done;

    // Sequencer side: issues starts and addresses, receives done flags.
    modport master (
        output src_req_start, src_base_addr, sink_req_start, sink_base_addr,
        input  src_done, sink_done
    );

    // Streamer side.
    modport slave (
        input  src_req_start, src_base_addr, sink_req_start, sink_base_addr,
        output src_done, sink_done
    );

endinterface

// File: rtl/vfpu_stream_done_tracker.sv
// Sticky per-stream done bits with an all-done summary.
module vfpu_stream_done_tracker #(
    parameter int unsigned NB_STREAMS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  set_en_i,
    input  logic [NB_STREAMS-1:0] done_i,
    output logic                  all_done_o
);

    logic [NB_STREAMS-1:0] sticky_q;

    // Accumulate done pulses while enabled; clear takes priority over set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sticky_q <= '0;
        end else if (clear_i) begin
            sticky_q <= '0;
        end else if (set_en_i) begin
            sticky_q <= sticky_q | done_i;
        end
    end

    // Pulses of the current cycle count, so completion needs no extra cycle.
    assign all_done_o = &(sticky_q | (done_i & {NB_STREAMS{set_en_i}}));

endmodule

// File: rtl/vfpu_tile_sequencer.sv
// Runs a programmed number of tiles: starts all source streams and the sink
// with per-tile base addresses, waits for every done, then advances.
module vfpu_tile_sequencer
    import vfpu_tile_sequencer_pkg::*;
#(
    parameter int unsigned NB_OPERANDS    = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TILE_CNT_WIDTH = 16,
    parameter int unsigned TIMEOUT_WIDTH  = 20
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   clear_i,
    input  logic                                   start_i,
    input  logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] cfg_src_base_i,
    input  logic [ADDR_WIDTH-1:0]                  cfg_sink_base_i,
    input  logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] cfg_src_stride_i,
    input  logic [ADDR_WIDTH-1:0]                  cfg_sink_stride_i,
    input  logic [TILE_CNT_WIDTH-1:0]              cfg_n_tiles_i,
    input  logic [TIMEOUT_WIDTH-1:0]               cfg_timeout_i,
    vfpu_tile_sequencer_if.master                  strm,
    output logic                                   busy_o,
    output logic [TILE_CNT_WIDTH-1:0]              tile_idx_o,
    output logic                                   done_o,
    output logic                                   error_o
);

    seq_state_e state_q;

    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_base_q;
    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_stride_q;
    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_off_q;
    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_addr_q;
    logic [ADDR_WIDTH-1:0]                  sink_base_q;
    logic [ADDR_WIDTH-1:0]                  sink_stride_q;
    logic [ADDR_WIDTH-1:0]                  sink_off_q;
    logic [ADDR_WIDTH-1:0]                  sink_addr_q;
    logic [TILE_CNT_WIDTH-1:0]              n_tiles_q;
    logic [TIMEOUT_WIDTH-1:0]               timeout_q;
    logic [TIMEOUT_WIDTH-1:0]               wd_q;
    logic [TILE_CNT_WIDTH-1:0]              tile_idx_q;
    logic [NB_OPERANDS-1:0]                 src_req_q;
    logic                                   sink_req_q;
    logic                                   done_q;
    logic                                   error_q;

    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_off_nxt;
    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_addr_nxt;
    logic [ADDR_WIDTH-1:0]                  sink_off_nxt;
    logic [ADDR_WIDTH-1:0]                  sink_addr_nxt;
    logic [TILE_CNT_WIDTH-1:0]              tile_nxt;
    logic                                   all_done;
    logic                                   timeout_hit;

    // Next-tile offsets and addresses; additions wrap modulo 2^ADDR_WIDTH.
    always_comb begin
        src_off_nxt  = '0;
        src_addr_nxt = '0;
        for (int unsigned i = 0; i < NB_OPERANDS; i++) begin
            src_off_nxt[i]  = src_off_q[i] + src_stride_q[i];
            src_addr_nxt[i] = src_base_q[i] + src_off_nxt[i];
        end
    end

    assign sink_off_nxt  = sink_off_q + sink_stride_q;
    assign sink_addr_nxt = sink_base_q + sink_off_nxt;
    assign tile_nxt      = tile_idx_q + TILE_CNT_WIDTH'(1);
    assign timeout_hit   = (timeout_q != '0) && (wd_q == timeout_q - TIMEOUT_WIDTH'(1));

    vfpu_stream_done_tracker #(
        .NB_STREAMS (NB_OPERANDS + 1)
    ) i_done_tracker (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i || (state_q == ISSUE)),
        .set_en_i   (state_q == WAIT),
        .done_i     ({strm.sink_done, strm.src_done}),
        .all_done_o (all_done)
    );

    // Sequencer FSM with registered start/done pulses and address outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            src_base_q    <= '0;
            src_stride_q  <= '0;
            src_off_q     <= '0;
            src_addr_q    <= '0;
            sink_base_q   <= '0;
            sink_stride_q <= '0;
            sink_off_q    <= '0;
            sink_addr_q   <= '0;
            n_tiles_q     <= '0;
            timeout_q     <= '0;
            wd_q          <= '0;
            tile_idx_q    <= '0;
            src_req_q     <= '0;
            sink_req_q    <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            src_off_q   <= '0;
            src_addr_q  <= '0;
            sink_off_q  <= '0;
            sink_addr_q <= '0;
            wd_q        <= '0;
            tile_idx_q  <= '0;
            src_req_q   <= '0;
            sink_req_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            src_req_q  <= '0;
            sink_req_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        src_base_q    <= cfg_src_base_i;
                        src_stride_q  <= cfg_src_stride_i;
                        sink_base_q   <= cfg_sink_base_i;
                        sink_stride_q <= cfg_sink_stride_i;
                        n_tiles_q     <= cfg_n_tiles_i;
                        timeout_q     <= cfg_timeout_i;
                        src_off_q     <= '0;
                        sink_off_q    <= '0;
                        src_addr_q    <= cfg_src_base_i;
                        sink_addr_q   <= cfg_sink_base_i;
                        tile_idx_q    <= '0;
                        if (cfg_n_tiles_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ISSUE;
                            error_q    <= 1'b0;
                            src_req_q  <= '1;
                            sink_req_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    wd_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    wd_q <= wd_q + TIMEOUT_WIDTH'(1);
                    if (all_done) begin
                        state_q <= NEXT;
                    end else if (timeout_hit) begin
                        error_q <= 1'b1;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                NEXT: begin
                    src_off_q   <= src_off_nxt;
                    src_addr_q  <= src_addr_nxt;
                    sink_off_q  <= sink_off_nxt;
                    sink_addr_q <= sink_addr_nxt;
                    tile_idx_q  <= tile_nxt;
                    if (tile_nxt == n_tiles_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= ISSUE;
                        src_req_q  <= '1;
                        sink_req_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign strm.src_req_start  = src_req_q;
    assign strm.src_base_addr  = src_addr_q;
    assign strm.sink_req_start = sink_req_q;
    assign strm.sink_base_addr = sink_addr_q;
    assign busy_o              = (state_q != IDLE);
    assign tile_idx_o          = tile_idx_q;
    assign done_o              = done_q;
    assign error_o             = error_q;

endmodule
